button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N_CH, default 5, meaning number of independent button channels (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable samples required to accept a new level (>=1).
REQ-003 SHALL have parameter REPEAT_DELAY, default 12500000, meaning cycles from accepted press to first auto-repeat pulse (>=1).
REQ-004 SHALL have parameter REPEAT_RATE, default 2500000, meaning cycles between subsequent auto-repeat pulses (>=1).
REQ-005 SHALL have port clock, input, 1, sole clock, with all state updating on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port noisy_in, input, N_CH, raw asynchronous button levels, active-high.
REQ-008 SHALL have port repeat_en, input, N_CH, per-channel auto-repeat enable.
REQ-009 SHALL have port clean_out, output, N_CH, debounced level.
REQ-010 SHALL have port rise_out, output, N_CH, one-cycle pulse on accepted press.
REQ-011 SHALL have port fall_out, output, N_CH, one-cycle pulse on accepted release.
REQ-012 SHALL have port repeat_out, output, N_CH, press pulse plus auto-repeat pulses.

Function
REQ-013 SHALL process each channel identically and independently; no channel's state affects another.
REQ-014 SHALL pass each noisy_in bit through a two-flop synchronizer; its second-stage output is sample s.
REQ-015 SHALL keep a per-channel counter of width $clog2(DEBOUNCE_CYCLES+1); cleared on any cycle where s == clean_out.
REQ-016 SHALL, on a cycle where s != clean_out and counter == DEBOUNCE_CYCLES-1, load clean_out <= s and clear the counter; otherwise increment on mismatch.
REQ-017 SHALL therefore update clean_out on edge E0+DEBOUNCE_CYCLES+1, where E0 is the first edge capturing the new level into the synchronizer, given no intervening bounce.
REQ-018 SHALL discard any excursion of s lasting fewer than DEBOUNCE_CYCLES samples: no change on clean_out, rise_out, fall_out, or repeat_out.
REQ-019 SHALL assert rise_out (fall_out) for exactly the first cycle in which clean_out reads 1 (0) after a change; both are registered.
REQ-020 SHALL assert repeat_out coincident with every rise_out regardless of repeat_en.
REQ-021 SHALL keep a per-channel hold counter of width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1), cleared on rise_out.
REQ-022 SHALL implement a per-channel FSM with states IDLE, DELAY, REPEAT:
- IDLE -> DELAY on accepted press.
- DELAY -> REPEAT after REPEAT_DELAY cycles, pulsing repeat_out if repeat_en.
- REPEAT pulses repeat_out every REPEAT_RATE cycles while repeat_en.
- Any state -> IDLE on accepted release, with no repeat_out that cycle.
REQ-023 SHALL, while repeat_en is low in DELAY/REPEAT, keep counting but suppress auto-repeat pulses; raising repeat_en resumes pulses on the next counter expiry without re-arming the delay.
REQ-024 SHALL give release priority: if release acceptance and a repeat expiry coincide, fall_out=1 and repeat_out=0.
REQ-025 SHALL saturate no counter beyond its terminal value; wrap-around is forbidden.

Reset
REQ-026 SHALL, with reset high at a clock edge, clear the synchronizers, all counters, clean_out, rise_out, fall_out, and repeat_out to 0, and set every FSM to IDLE.
REQ-027 SHALL generate no rise_out/fall_out/repeat_out on the first cycle after reset; an input held high through reset is accepted only after a full debounce interval.
REQ-028 SHALL abort any in-progress debounce or repeat when reset is asserted mid-operation, with no residual pulses.

Verification (bench parameters: N_CH=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-029 SHALL cover: noisy_in[0] 0->1 captured at E0 -> clean_out[0]=1 after E5; rise_out[0]=repeat_out[0]=1 only during the cycle after E5; ch1 unaffected.
REQ-030 SHALL cover: a 3-cycle glitch high on noisy_in[1] -> all outputs of ch1 remain 0.
REQ-031 SHALL cover: ch0 held 30 cycles with repeat_en[0]=1 -> repeat_out[0] pulses at press, press+10, +13, +16, ...; none after the accepted release.
REQ-032 SHALL cover: the same hold with repeat_en[0]=0 -> exactly one repeat_out[0] pulse (the press pulse).
REQ-033 SHALL cover: release accepted on the same cycle as a repeat expiry -> fall_out=1 and repeat_out=0.
REQ-034 SHALL cover: reset asserted mid-DELAY with the button still held -> all outputs 0 after reset; re-press accepted 5 edges after reset deasserts.

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Multi-channel push-button front end. Each channel synchronizes a raw
//   button level, debounces it, produces single-cycle press/release strobes
//   and an auto-repeat strobe train while the button is held.
//
// Parameters:
//   N_CH            number of independent channels (1..16)
//   DEBOUNCE_CYCLES consecutive stable samples needed to accept a new level
//   REPEAT_DELAY    cycles from accepted press to the first auto-repeat pulse
//   REPEAT_RATE     cycles between subsequent auto-repeat pulses
//
// Ports:
//   clock       sole clock, rising edge
//   reset       synchronous, active-high
//   noisy_in    raw asynchronous button levels (active-high)
//   repeat_en   per-channel auto-repeat enable
//   clean_out   debounced level
//   rise_out    one-cycle strobe on accepted press
//   fall_out    one-cycle strobe on accepted release
//   repeat_out  press strobe plus auto-repeat strobes
//
// Per-channel repeat FSM:
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | button released (or just reset), hold counter parked at 0
//   DELAY  | press accepted, counting toward the first auto-repeat
//   REPEAT | first repeat done, strobing every REPEAT_RATE cycles
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_CH            = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 2500000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] noisy_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_out,
    output logic [N_CH-1:0] fall_out,
    output logic [N_CH-1:0] repeat_out
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    // Terminal values: the counters compare against N-1 so that the registered
    // strobes land exactly N cycles after the event that started the count.
    localparam logic [DB_W-1:0]   DB_TC    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_TC = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] RATE_TC  = HOLD_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Two-flop synchronizer, all channels in parallel.
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= noisy_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch

        logic              s;
        logic              mismatch;
        logic              accept;
        logic              press;
        logic              release_acc;
        logic              auto_pulse;

        logic [DB_W-1:0]   db_cnt_q,   db_cnt_d;
        logic              clean_q,    clean_d;
        logic              rise_q,     rise_d;
        logic              fall_q,     fall_d;
        logic              rep_q,      rep_d;
        logic [HOLD_W-1:0] hold_q,     hold_d;
        state_t            state_q,    state_d;

        assign s = sync2_q[g];

        // Debounce: any sample matching the accepted level restarts the count,
        // so only an unbroken run of DEBOUNCE_CYCLES new samples is accepted.
        always_comb begin
            mismatch    = (s != clean_q);
            accept      = mismatch && (db_cnt_q == DB_TC);
            press       = accept && s;
            release_acc = accept && !s;

            db_cnt_d = db_cnt_q;
            clean_d  = clean_q;
            if (!mismatch || accept) begin
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
            if (accept) begin
                clean_d = s;
            end

            rise_d = press;
            fall_d = release_acc;
        end

        // Repeat FSM. Expiry always advances the state and reloads the hold
        // counter; repeat_en only gates the strobe, so re-enabling mid-hold
        // resumes on the next natural expiry without re-arming the delay.
        always_comb begin
            state_d    = state_q;
            hold_d     = hold_q;
            auto_pulse = 1'b0;

            case (state_q)
                IDLE: begin
                    hold_d = '0;
                    if (press) begin
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    if (hold_q == DELAY_TC) begin
                        state_d    = REPEAT;
                        hold_d     = '0;
                        auto_pulse = repeat_en[g];
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (hold_q == RATE_TC) begin
                        hold_d     = '0;
                        auto_pulse = repeat_en[g];
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase

            if (press) begin
                hold_d = '0;
            end

            // Release wins over a coincident repeat expiry.
            if (release_acc) begin
                state_d    = IDLE;
                hold_d     = '0;
                auto_pulse = 1'b0;
            end

            rep_d = press | auto_pulse;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                db_cnt_q <= '0;
                clean_q  <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                rep_q    <= 1'b0;
                hold_q   <= '0;
                state_q  <= IDLE;
            end else begin
                db_cnt_q <= db_cnt_d;
                clean_q  <= clean_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                rep_q    <= rep_d;
                hold_q   <= hold_d;
                state_q  <= state_d;
            end
        end

        assign clean_out[g]  = clean_q;
        assign rise_out[g]   = rise_q;
        assign fall_out[g]   = fall_q;
        assign repeat_out[g] = rep_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed stimulus for a 2-channel conditioner (debounce 4, repeat delay 10,
// repeat rate 3). Each stimulus step pushes the strobe events it should cause
// into a queue; a monitor pops one event whenever any strobe output is high
// and compares cycle number and the full output snapshot.
//
// Timing used for expected cycles: an input changed on the falling edge of
// cycle k is captured at edge k+1, and the accepted change (with its strobes)
// is visible after edge k+6. Auto-repeats follow the press by 10, 13, 16 ...
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int N_CH = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [N_CH-1:0] noisy_in;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] clean_out;
    logic [N_CH-1:0] rise_out;
    logic [N_CH-1:0] fall_out;
    logic [N_CH-1:0] repeat_out;

    button_conditioner #(
        .N_CH           (N_CH),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .noisy_in  (noisy_in),
        .repeat_en (repeat_en),
        .clean_out (clean_out),
        .rise_out  (rise_out),
        .fall_out  (fall_out),
        .repeat_out(repeat_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] rep;
        logic [1:0] clean;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    function automatic void push(int c, logic [1:0] r, logic [1:0] f,
                                 logic [1:0] p, logic [1:0] cl);
        ev_t e;
        e.cyc   = c;
        e.rise  = r;
        e.fall  = f;
        e.rep   = p;
        e.clean = cl;
        exp_q.push_back(e);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: every strobe must match the next queued event.
    always @(negedge clock) begin
        ev_t e;
        if ((rise_out | fall_out | repeat_out) != '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe at cyc %0d: rise=%b fall=%b rep=%b clean=%b, none expected",
                         cyc, rise_out, fall_out, repeat_out, clean_out);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL strobe_cycle: got cyc %0d expected cyc %0d", cyc, e.cyc);
                end
                total++;
                if ({rise_out, fall_out, repeat_out, clean_out} !== {e.rise, e.fall, e.rep, e.clean}) begin
                    bad++;
                    $display("FAIL strobe_value at cyc %0d: got r=%b f=%b p=%b c=%b expected r=%b f=%b p=%b c=%b",
                             cyc, rise_out, fall_out, repeat_out, clean_out,
                             e.rise, e.fall, e.rep, e.clean);
                end
            end
        end
    end

    initial begin
        int k;
        reset     = 1'b1;
        noisy_in  = '0;
        repeat_en = '0;

        // Reset state
        step(3);
        check("reset_clean",  32'(clean_out),  32'h0);
        check("reset_rise",   32'(rise_out),   32'h0);
        check("reset_fall",   32'(fall_out),   32'h0);
        check("reset_repeat", 32'(repeat_out), 32'h0);
        reset = 1'b0;
        step(1);
        check("post_reset_outs", 32'({clean_out, rise_out, fall_out, repeat_out}), 32'h0);

        // Hold ch0 30 cycles with auto-repeat enabled
        step(1);
        k = cyc;
        repeat_en   = 2'b01;
        noisy_in[0] = 1'b1;
        push(k + 6, 2'b01, 2'b00, 2'b01, 2'b01);
        for (int t = 16; t <= 34; t += 3) push(k + t, 2'b00, 2'b00, 2'b01, 2'b01);
        push(k + 36, 2'b00, 2'b01, 2'b00, 2'b00);
        step(5);
        check("debounce_not_yet", 32'(clean_out), 32'h0);
        step(5);
        check("held_clean", 32'(clean_out), 32'h1);
        step(20);
        noisy_in[0] = 1'b0;
        step(12);
        check("hold_en_clean", 32'(clean_out), 32'h0);
        check("hold_en_drain", 32'(exp_q.size()), 32'd0);

        // Same hold with auto-repeat disabled: press strobe only
        k = cyc;
        repeat_en   = 2'b00;
        noisy_in[0] = 1'b1;
        push(k + 6, 2'b01, 2'b00, 2'b01, 2'b01);
        push(k + 36, 2'b00, 2'b01, 2'b00, 2'b00);
        step(30);
        noisy_in[0] = 1'b0;
        step(12);
        check("hold_dis_drain", 32'(exp_q.size()), 32'd0);

        // 3-cycle glitch on ch1 is rejected
        repeat_en   = 2'b10;
        noisy_in[1] = 1'b1;
        step(3);
        noisy_in[1] = 1'b0;
        step(10);
        check("glitch_clean", 32'(clean_out), 32'h0);

        // 4-cycle excursion on ch1 is exactly long enough
        k = cyc;
        repeat_en   = 2'b00;
        noisy_in[1] = 1'b1;
        push(k + 6, 2'b10, 2'b00, 2'b10, 2'b10);
        push(k + 10, 2'b00, 2'b10, 2'b00, 2'b00);
        step(4);
        noisy_in[1] = 1'b0;
        step(12);
        check("min_pulse_drain", 32'(exp_q.size()), 32'd0);

        // Release accepted on the same edge as a repeat expiry
        k = cyc;
        repeat_en   = 2'b01;
        noisy_in[0] = 1'b1;
        push(k + 6,  2'b01, 2'b00, 2'b01, 2'b01);
        push(k + 16, 2'b00, 2'b00, 2'b01, 2'b01);
        push(k + 19, 2'b00, 2'b00, 2'b01, 2'b01);
        push(k + 22, 2'b00, 2'b01, 2'b00, 2'b00);
        step(16);
        noisy_in[0] = 1'b0;
        step(12);
        check("coincide_drain", 32'(exp_q.size()), 32'd0);

        // Reset mid-DELAY with ch0 still held
        k = cyc;
        repeat_en   = 2'b01;
        noisy_in[0] = 1'b1;
        push(k + 6, 2'b01, 2'b00, 2'b01, 2'b01);
        step(10);
        reset = 1'b1;
        step(1);
        check("mid_reset_outs", 32'({clean_out, rise_out, fall_out, repeat_out}), 32'h0);
        step(1);
        reset = 1'b0;
        push(k + 18, 2'b01, 2'b00, 2'b01, 2'b01);
        push(k + 26, 2'b00, 2'b01, 2'b00, 2'b00);
        step(1);
        check("after_reset_outs", 32'({clean_out, rise_out, fall_out, repeat_out}), 32'h0);
        step(4);
        check("repress_not_yet", 32'(clean_out), 32'h0);
        step(3);
        check("repress_clean", 32'(clean_out), 32'h1);
        noisy_in[0] = 1'b0;
        step(12);
        check("reset_case_drain", 32'(exp_q.size()), 32'd0);

        step(5);
        check("final_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
